// File: rtl/ppi_mac_serial.sv
// Serial polyphase interpolator: one shared MAC, C+1 cycles per phase, L phases per input sample.
// Optional macro PPI_MAC_SERIAL_SAT_EN saturates o_data instead of wrapping when narrowing the accumulator.
module ppi_mac_serial #(
  parameter int gp_idata_width          = 8,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 12,
  parameter int gp_coeff_width          = 16,
  parameter int gp_odata_width          = gp_idata_width + gp_coeff_width +
                                          (gp_coeff_length + gp_interpolation_factor - 1) / gp_interpolation_factor,
  // Half of the symmetric prototype, c_coeff[i] in bits [i*W +: W]
  parameter logic [((gp_coeff_length + 1) / 2) * gp_coeff_width - 1:0] gp_coeff =
    {16'sd2048, 16'sd1536, 16'sd768, 16'sd128, -16'sd96, -16'sd32}
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_an,
  input  logic                                       i_ena,
  input  logic signed [gp_idata_width-1:0]           i_data,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  output logic signed [gp_odata_width-1:0]           o_data,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [$clog2(gp_interpolation_factor)-1:0] o_phase
);

  localparam int IW   = gp_idata_width;
  localparam int L    = gp_interpolation_factor;
  localparam int N    = gp_coeff_length;
  localparam int CW   = gp_coeff_width;
  localparam int OW   = gp_odata_width;
  localparam int C    = (N + L - 1) / L;
  localparam int A    = IW + CW + C;
  localparam int HALF = (N + 1) / 2;
  localparam int PW   = $clog2(L);
  localparam int KW   = $clog2(C + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                state, state_nxt;
  logic signed [IW-1:0]  x [C];
  logic signed [A-1:0]   acc;
  logic [PW-1:0]         p;
  logic [KW-1:0]         k;
  logic signed [IW-1:0]  x_sel;
  logic signed [CW-1:0]  h_sel;
  logic signed [IW+CW-1:0] prod;
  logic [OW-1:0]         out_val;
  logic                  mac_done;

  function automatic logic signed [CW-1:0] h_at(input int n);
    if (n < HALF)   return gp_coeff[n*CW +: CW];
    else if (n < N) return gp_coeff[(N-1-n)*CW +: CW];
    else            return '0;
  endfunction

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < C; i++)
      if (k == KW'(i)) x_sel = x[i];
    h_sel = h_at(int'(p) + int'(k) * L);
    prod  = x_sel * h_sel;
  end

  // k counts one past the last tap: that extra cycle registers the finished sum.
  assign mac_done = (k == KW'(C));

`ifdef PPI_MAC_SERIAL_SAT_EN
  localparam logic signed [A-1:0] SAT_MAX = A'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [A-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (acc > SAT_MAX)      out_val = SAT_MAX[OW-1:0];
    else if (acc < SAT_MIN) out_val = SAT_MIN[OW-1:0];
    else                    out_val = acc[OW-1:0];
  end
`else
  assign out_val = acc[OW-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an)   state <= S_IDLE;
    else if (i_ena)  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = i_ena;
        if (i_valid) state_nxt = S_MAC;
      end
      S_MAC:   if (mac_done) state_nxt = S_OUT;
      S_OUT:   if (i_ready)  state_nxt = (p == PW'(L - 1)) ? S_IDLE : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      for (int i = 0; i < C; i++) x[i] <= '0;
      acc     <= '0;
      p       <= '0;
      k       <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_phase <= '0;
    end else if (i_ena) begin
      case (state)
        S_IDLE: if (i_valid) begin
          x[0] <= i_data;
          for (int i = 1; i < C; i++) x[i] <= x[i-1];
          p   <= '0;
          k   <= '0;
          acc <= '0;
        end
        S_MAC: if (mac_done) begin
          o_data  <= out_val;
          o_phase <= p;
          o_valid <= 1'b1;
        end else begin
          acc <= acc + A'(prod);
          k   <= k + KW'(1);
        end
        S_OUT: if (i_ready) begin
          o_valid <= 1'b0;
          if (p != PW'(L - 1)) begin
            p   <= p + PW'(1);
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_mac_serial.sv
// Directed bench for ppi_mac_serial: N=6, L=2, c_coeff={1,2,3}; outputs checked against a queued model.
module tb_ppi_mac_serial;
  localparam int IW = 8;
  localparam int L  = 2;
  localparam int N  = 6;
  localparam int CW = 16;
  localparam int C  = 3;
  localparam int OW = IW + CW + C;
  localparam logic [47:0] COEF = {16'd3, 16'd2, 16'd1};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ena = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [IW-1:0] in_data = '0;

  logic                 rdy, ovalid, rdy4, ovalid4;
  logic signed [OW-1:0] odata;
  logic signed [3:0]    odata4;
  logic [0:0]           ophase, ophase4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic signed [OW-1:0] d;
    logic [0:0]           p;
  } exp_t;
  exp_t exp_q[$];
  int h_tb [6] = '{1, 2, 3, 3, 2, 1};
  int hist [3] = '{0, 0, 0};

  ppi_mac_serial #(.gp_idata_width(IW), .gp_interpolation_factor(L), .gp_coeff_length(N),
                   .gp_coeff_width(CW), .gp_coeff(COEF)) dut (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(in_data), .i_valid(in_valid),
    .o_ready(rdy), .o_data(odata), .o_valid(ovalid), .i_ready(out_ready), .o_phase(ophase));

  ppi_mac_serial #(.gp_idata_width(IW), .gp_interpolation_factor(L), .gp_coeff_length(N),
                   .gp_coeff_width(CW), .gp_odata_width(4), .gp_coeff(COEF)) dut4 (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(in_data), .i_valid(in_valid),
    .o_ready(rdy4), .o_data(odata4), .o_valid(ovalid4), .i_ready(out_ready), .o_phase(ophase4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_push(input int v);
    exp_t e;
    int   y;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = v;
    for (int ph = 0; ph < L; ph++) begin
      y = 0;
      for (int kk = 0; kk < C; kk++) y += h_tb[ph + kk * L] * hist[kk];
      e.d = OW'(y);
      e.p = ph[0:0];
      exp_q.push_back(e);
    end
  endtask

  // A handshake completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ena && ovalid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_output observed=%0d expected=none", odata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_data", odata, e.d);
        chk("o_phase", ophase, e.p);
      end
    end
  end

  task automatic send(input int v);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("send_ready_wait", n < 200, 1);
    in_valid = 1'b1;
    in_data  = v[IW-1:0];
    model_push(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (ovalid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rdy !== 1'b1) && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    #12;
    chk("rst_o_valid", ovalid, 0);
    chk("rst_o_data", odata, 0);
    chk("rst_o_phase", ophase, 0);
    chk("rst_o_ready", rdy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_o_ready", rdy, 1);

    // impulse
    send(1);
    wait_valid(lat);
    chk("impulse_latency", lat, 4);
    send(0); send(0); send(0);
    drain();

    // step
    repeat (4) send(100);
    drain();

    // enable low in IDLE blocks acceptance
    ena = 1'b0;
    #1;
    chk("ena_low_o_ready", rdy, 0);
    in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    ena = 1'b1;
    #1;
    chk("ena_high_o_ready", rdy, 1);

    // enable low for 3 cycles mid-MAC
    send(5);
    @(posedge clk); #1;
    lat = 1;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    chk("ena_stall_no_valid", ovalid, 0);
    ena = 1'b1;
    while (ovalid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("ena_stall_latency", lat, 7);
    drain();

    // backpressure in OUT, i_valid pulses ignored
    send(7);
    wait_valid(lat);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'sd55;
      @(posedge clk); #1;
      chk("bp_o_valid", ovalid, 1);
      chk("bp_o_data", odata, exp_q[0].d);
      chk("bp_o_phase", ophase, exp_q[0].p);
      chk("bp_o_ready", rdy, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset mid-OUT
    send(9);
    wait_valid(lat);
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_o_valid", ovalid, 0);
    chk("rst_mid_o_data", odata, 0);
    chk("rst_mid_o_phase", ophase, 0);
    exp_q.delete();
    hist = '{0, 0, 0};
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_o_ready", rdy, 1);
    out_ready = 1'b1;
    send(1); send(0); send(0);
    drain();

    // narrow output: 127 and 254 into 4 bits
    send(127);
    n = 0;
    while (ovalid4 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("narrow_p0_phase", ophase4, 0);
`ifdef PPI_MAC_SERIAL_SAT_EN
    chk("narrow_p0_data", odata4, 7);
`else
    chk("narrow_p0_data", odata4, -1);
`endif
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(ovalid4 === 1'b1 && ophase4 === 1'b1) && n < 100);
`ifdef PPI_MAC_SERIAL_SAT_EN
    chk("narrow_p1_data", odata4, 7);
`else
    chk("narrow_p1_data", odata4, -2);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
